// File: rtl/down_count_mon_pkg.sv
// Shared definitions for the down-counter monitor: FSM state encoding and widths.
package down_count_mon_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_TRACK = 2'd2
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; one-cycle update latency, no backpressure.
// A clear that coincides with an increment loads 1 so the coincident event is not lost.
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? W'(1) : '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/down_count_monitor.sv
// Locks onto a 3-bit down counter's q/q_bar sequence, flags illegal steps and counts wraps.
// All outputs registered: pulses appear one cycle after the offending q; purely observing, no backpressure.
module down_count_monitor
    import down_count_mon_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int WRAP_W   = 8,
    parameter int ERR_W    = 4,
    parameter int SYNC_LEN = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               t,
    input  logic [WIDTH-1:0]   q,
    input  logic [WIDTH-1:0]   q_bar,
    input  logic               clr_err,
    output logic               locked,
    output logic               err,
    output logic               err_pulse,
    output logic [ERR_W-1:0]   err_cnt,
    output logic               wrap_pulse,
    output logic [WRAP_W-1:0]  wrap_cnt,
    output logic [STATE_W-1:0] state
);

    localparam int GW = $clog2(SYNC_LEN + 1);

    state_t           st;
    logic [WIDTH-1:0] q_prev;
    logic             t_prev;
    logic [GW-1:0]    good_cnt;

    logic [WIDTH-1:0] exp_q;
    logic             step_good;
    logic             wrap_step;
    logic             err_event;

    // The step is judged on what the counter showed one edge ago plus the enable it saw then.
    assign exp_q     = t_prev ? (q_prev - WIDTH'(1)) : q_prev;
    assign step_good = (q == exp_q) && (q_bar == ~q);
    assign wrap_step = t_prev && (q_prev == '0) && (q == '1);
    assign err_event = (st == ST_TRACK) && !step_good;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st         <= ST_IDLE;
            q_prev     <= '0;
            t_prev     <= 1'b0;
            good_cnt   <= '0;
            locked     <= 1'b0;
            err        <= 1'b0;
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
            wrap_cnt   <= '0;
        end else begin
            q_prev     <= q;
            t_prev     <= t;
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;

            case (st)
                ST_IDLE: begin
                    good_cnt <= '0;
                    st       <= ST_SYNC;
                end
                ST_SYNC: begin
                    if (!step_good) begin
                        good_cnt <= '0;
                    end else if (good_cnt == GW'(SYNC_LEN - 1)) begin
                        good_cnt <= '0;
                        st       <= ST_TRACK;
                        locked   <= 1'b1;
                    end else begin
                        good_cnt <= good_cnt + GW'(1);
                    end
                end
                ST_TRACK: begin
                    if (step_good) begin
                        if (wrap_step) begin
                            wrap_pulse <= 1'b1;
                            wrap_cnt   <= wrap_cnt + WRAP_W'(1);
                        end
                    end else begin
                        err_pulse <= 1'b1;
                        good_cnt  <= '0;
                        st        <= ST_SYNC;
                        locked    <= 1'b0;
                    end
                end
                default: begin
                    good_cnt <= '0;
                    st       <= ST_IDLE;
                    locked   <= 1'b0;
                end
            endcase

            // A new error outranks a clear on the same edge.
            if (err_event) begin
                err <= 1'b1;
            end else if (clr_err) begin
                err <= 1'b0;
            end
        end
    end

    sat_counter #(
        .W (ERR_W)
    ) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_err),
        .inc (err_event),
        .cnt (err_cnt)
    );

    assign state = st;

endmodule

// File: tb/tb_down_count_monitor.sv
// Directed-vector bench for down_count_monitor with hand-computed expectations.
module tb_down_count_monitor;

    localparam int WIDTH    = 3;
    localparam int WRAP_W   = 8;
    localparam int ERR_W    = 4;
    localparam int SYNC_LEN = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              t = 1'b0;
    logic [WIDTH-1:0]  q = '0;
    logic [WIDTH-1:0]  q_bar = '1;
    logic              clr_err = 1'b0;
    logic              locked;
    logic              err;
    logic              err_pulse;
    logic [ERR_W-1:0]  err_cnt;
    logic              wrap_pulse;
    logic [WRAP_W-1:0] wrap_cnt;
    logic [1:0]        state;

    int vectors = 0;
    int miscompares = 0;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] h;

    always #5 clk = ~clk;

    down_count_monitor #(
        .WIDTH    (WIDTH),
        .WRAP_W   (WRAP_W),
        .ERR_W    (ERR_W),
        .SYNC_LEN (SYNC_LEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .t          (t),
        .q          (q),
        .q_bar      (q_bar),
        .clr_err    (clr_err),
        .locked     (locked),
        .err        (err),
        .err_pulse  (err_pulse),
        .err_cnt    (err_cnt),
        .wrap_pulse (wrap_pulse),
        .wrap_cnt   (wrap_cnt),
        .state      (state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Present one sample, clock it in, settle just past the edge.
    task automatic drive(input logic tv, input logic [WIDTH-1:0] qv, input logic [WIDTH-1:0] qbv);
        t     = tv;
        q     = qv;
        q_bar = qbv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_locked", 32'(locked), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        chk("rst_wrap_cnt", 32'(wrap_cnt), 0);
        chk("rst_state", 32'(state), 0);
        rst = 1'b0;

        // Free-running t=1 from 0: lock at edge 3, wraps (0->7) in TRACK at edges 10 and 18
        c = '0;
        for (int e = 1; e <= 20; e++) begin
            drive(1'b1, c, ~c);
            c = c - 3'd1;
            if (e == 1) chk("sync_entry_state", 32'(state), 1);
            if (e == 2) chk("locked_edge2", 32'(locked), 0);
            if (e == 3) chk("locked_edge3", 32'(locked), 1);
            chk("run_wrap_pulse", 32'(wrap_pulse), (e == 10 || e == 18) ? 1 : 0);
            chk("run_err", 32'(err), 0);
        end
        chk("run_wrap_cnt", 32'(wrap_cnt), 2);

        // Hold with t=0: q stays at 4
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, c, ~c);
            chk("hold_locked", 32'(locked), 1);
            chk("hold_wrap_pulse", 32'(wrap_pulse), 0);
        end
        chk("hold_err_cnt", 32'(err_cnt), 0);

        // Count 4..0,7,6,5 then skip to 3
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, c, ~c);
            c = c - 3'd1;
        end
        chk("pre_skip_err_pulse", 32'(err_pulse), 0);
        chk("pre_skip_wrap_cnt", 32'(wrap_cnt), 3);
        drive(1'b1, 3'd3, 3'd4);
        chk("skip_err_pulse", 32'(err_pulse), 1);
        chk("skip_err", 32'(err), 1);
        chk("skip_err_cnt", 32'(err_cnt), 1);
        chk("skip_locked", 32'(locked), 0);
        chk("skip_state", 32'(state), 1);
        drive(1'b1, 3'd2, 3'd5);
        chk("relock1_err_pulse", 32'(err_pulse), 0);
        chk("relock1_locked", 32'(locked), 0);
        drive(1'b1, 3'd1, 3'd6);
        chk("relock2_locked", 32'(locked), 1);

        // Clear with a good step
        clr_err = 1'b1;
        drive(1'b1, 3'd0, 3'd7);
        clr_err = 1'b0;
        chk("clr_err", 32'(err), 0);
        chk("clr_err_cnt", 32'(err_cnt), 0);
        chk("clr_locked", 32'(locked), 1);

        // 7,6,5 then q=4 with a broken complement
        drive(1'b1, 3'd7, 3'd0);
        drive(1'b1, 3'd6, 3'd1);
        drive(1'b1, 3'd5, 3'd2);
        chk("qbar_pre_wrap_cnt", 32'(wrap_cnt), 4);
        drive(1'b1, 3'd4, 3'b000);
        chk("qbar_err_cnt", 32'(err_cnt), 1);
        chk("qbar_state", 32'(state), 1);
        chk("qbar_err_pulse", 32'(err_pulse), 1);

        // 20 more errors, relocking between each: saturate at 15
        h = 3'd3;
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, h, ~h);
            drive(1'b0, h, ~h);
            chk("sat_relock", 32'(locked), 1);
            h = h ^ 3'b110;
            drive(1'b0, h, ~h);
            chk("sat_err_pulse", 32'(err_pulse), 1);
            chk("sat_err_cnt", 32'(err_cnt), (i + 2 > 15) ? 15 : i + 2);
        end

        clr_err = 1'b1;
        drive(1'b0, h, ~h);
        clr_err = 1'b0;
        chk("sat_clr_err", 32'(err), 0);
        chk("sat_clr_err_cnt", 32'(err_cnt), 0);
        chk("sat_clr_state", 32'(state), 1);

        // Clear coincident with an error
        drive(1'b0, h, ~h);
        chk("coinc_locked", 32'(locked), 1);
        h = h ^ 3'b110;
        clr_err = 1'b1;
        drive(1'b0, h, ~h);
        clr_err = 1'b0;
        chk("coinc_err", 32'(err), 1);
        chk("coinc_err_cnt", 32'(err_cnt), 1);
        chk("coinc_err_pulse", 32'(err_pulse), 1);

        // Asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        chk("arst_locked", 32'(locked), 0);
        chk("arst_err", 32'(err), 0);
        chk("arst_err_pulse", 32'(err_pulse), 0);
        chk("arst_err_cnt", 32'(err_cnt), 0);
        chk("arst_wrap_cnt", 32'(wrap_cnt), 0);
        chk("arst_state", 32'(state), 0);
        #2;
        rst = 1'b0;

        // Relock needs 1+SYNC_LEN edges; the 0->7 step in SYNC is not a counted wrap
        drive(1'b1, 3'd0, 3'd7);
        drive(1'b1, 3'd7, 3'd0);
        chk("post_rst_locked2", 32'(locked), 0);
        drive(1'b1, 3'd6, 3'd1);
        chk("post_rst_locked3", 32'(locked), 1);
        chk("post_rst_wrap_cnt", 32'(wrap_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
